// File: rtl/pipe_ctrl_unit.sv
// ID-stage decode, ID/EX control register, load-use/flush hazard handling and
// RV32M multi-cycle occupancy counter for the pipelined RV32 core.
module pipe_ctrl_unit #(
  parameter int ALUOP_W = 5,
  parameter int EXTOP_W = 6,
  parameter int EN_MEXT = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [6:0]         Op,
  input  logic [6:0]         Funct7,
  input  logic [2:0]         Funct3,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic               flush,
  output logic [EXTOP_W-1:0] id_EXTOp,
  output logic               stall,
  output logic               ex_valid,
  output logic               ex_RegWrite,
  output logic               ex_MemWrite,
  output logic               ex_MemRead,
  output logic               ex_ALUSrc,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [1:0]         ex_WDSel,
  output logic [2:0]         ex_DMType,
  output logic [2:0]         ex_NPCOp,
  output logic [2:0]         ex_MDOp,
  output logic               ex_MDEn,
  output logic [4:0]         ex_rd,
  output logic               ex_illegal,
  output logic               md_busy
);

  localparam logic [6:0] OP_R = 7'b0110011, OP_L = 7'b0000011, OP_I = 7'b0010011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  localparam logic [ALUOP_W-1:0] A_LUI = ALUOP_W'(1), A_AUIPC = ALUOP_W'(2), A_ADD = ALUOP_W'(3),
                                 A_SUB = ALUOP_W'(4), A_BNE = ALUOP_W'(5), A_BLT = ALUOP_W'(6),
                                 A_BGE = ALUOP_W'(7), A_BLTU = ALUOP_W'(8), A_BGEU = ALUOP_W'(9),
                                 A_SLT = ALUOP_W'(10), A_SLTU = ALUOP_W'(11), A_XOR = ALUOP_W'(12),
                                 A_OR = ALUOP_W'(13), A_AND = ALUOP_W'(14), A_SLL = ALUOP_W'(15),
                                 A_SRL = ALUOP_W'(16), A_SRA = ALUOP_W'(17);

  localparam logic [EXTOP_W-1:0] X_SH = EXTOP_W'(6'b100000), X_I = EXTOP_W'(6'b010000),
                                 X_S = EXTOP_W'(6'b001000), X_B = EXTOP_W'(6'b000100),
                                 X_U = EXTOP_W'(6'b000010), X_J = EXTOP_W'(6'b000001);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef struct packed {
    logic               valid, reg_write, mem_write, mem_read, alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         wd_sel;
    logic [2:0]         dm_type, npc_op, md_op;
    logic               md_en;
    logic [4:0]         rd;
    logic               illegal;
  } ctrl_t;

  ctrl_t         dec, ex;
  logic [CW-1:0] cnt;
  logic          uses_rs1, uses_rs2, load_use;

  // alt selects sub/sra; callers only raise it where the encoding allows it
  function automatic logic [ALUOP_W-1:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? A_SUB : A_ADD;
      3'b001:  alu_fn = A_SLL;
      3'b010:  alu_fn = A_SLT;
      3'b011:  alu_fn = A_SLTU;
      3'b100:  alu_fn = A_XOR;
      3'b101:  alu_fn = alt ? A_SRA : A_SRL;
      3'b110:  alu_fn = A_OR;
      default: alu_fn = A_AND;
    endcase
  endfunction

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rd    = id_rd;
    id_EXTOp  = '0;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    case (Op)
      OP_R: begin
        uses_rs2      = 1'b1;
        dec.reg_write = 1'b1;
        if (Funct7 == 7'b0000001) begin
          if (EN_MEXT != 0) begin
            dec.md_en = 1'b1;
            dec.md_op = Funct3;
          end else dec.illegal = 1'b1;
        end else if (Funct7 == 7'b0000000 ||
                     (Funct7 == 7'b0100000 && (Funct3 == 3'b000 || Funct3 == 3'b101)))
          dec.alu_op = alu_fn(Funct3, Funct7[5]);
        else dec.illegal = 1'b1;
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        id_EXTOp      = X_I;
        dec.alu_op    = alu_fn(Funct3, (Funct3 == 3'b101) & Funct7[5]);
        if (Funct3 == 3'b001 || Funct3 == 3'b101) begin
          id_EXTOp = X_SH;
          if (!(Funct7 == 7'b0000000 || (Funct3 == 3'b101 && Funct7 == 7'b0100000)))
            dec.illegal = 1'b1;
        end
      end
      OP_L: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = A_ADD;
        dec.wd_sel    = 2'b01;
        id_EXTOp      = X_I;
        case (Funct3)
          3'b000:  dec.dm_type = 3'b011;
          3'b001:  dec.dm_type = 3'b001;
          3'b010:  dec.dm_type = 3'b000;
          3'b100:  dec.dm_type = 3'b100;
          3'b101:  dec.dm_type = 3'b010;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_S: begin
        uses_rs2      = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = A_ADD;
        id_EXTOp      = X_S;
        case (Funct3)
          3'b000:  dec.dm_type = 3'b011;
          3'b001:  dec.dm_type = 3'b001;
          3'b010:  dec.dm_type = 3'b000;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_B: begin
        uses_rs2   = 1'b1;
        dec.npc_op = 3'b001;
        id_EXTOp   = X_B;
        case (Funct3)
          3'b000:  dec.alu_op = A_SUB;
          3'b001:  dec.alu_op = A_BNE;
          3'b100:  dec.alu_op = A_BLT;
          3'b101:  dec.alu_op = A_BGE;
          3'b110:  dec.alu_op = A_BLTU;
          3'b111:  dec.alu_op = A_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        uses_rs1      = 1'b0;
        dec.reg_write = 1'b1;
        dec.alu_op    = A_ADD;
        dec.wd_sel    = 2'b10;
        dec.npc_op    = 3'b010;
        id_EXTOp      = X_J;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = A_ADD;
        dec.wd_sel    = 2'b10;
        dec.npc_op    = 3'b100;
        id_EXTOp      = X_I;
        if (Funct3 != 3'b000) dec.illegal = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        uses_rs1      = 1'b0;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = (Op == OP_LUI) ? A_LUI : A_AUIPC;
        id_EXTOp      = X_U;
      end
      default: dec.illegal = 1'b1;
    endcase
    // an illegal op travels down the pipe as a marker only, with no side effects
    if (dec.illegal) dec = '{valid: 1'b1, rd: id_rd, illegal: 1'b1, default: '0};
  end

  assign md_busy  = (cnt != '0);
  assign load_use = id_valid & ex.valid & ex.mem_read & (ex.rd != 5'd0) &
                    ((uses_rs1 & (ex.rd == id_rs1)) | (uses_rs2 & (ex.rd == id_rs2)));
  assign stall    = md_busy | (load_use & ~flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex  <= '0;
      cnt <= '0;
    end else if (md_busy) begin
      cnt <= cnt - CW'(1);
    end else if (flush || load_use || !id_valid) begin
      ex  <= '0;
    end else begin
      ex  <= dec;
      cnt <= !dec.md_en ? '0 : (Funct3[2] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1));
    end
  end

  assign ex_valid    = ex.valid;
  assign ex_RegWrite = ex.reg_write;
  assign ex_MemWrite = ex.mem_write;
  assign ex_MemRead  = ex.mem_read;
  assign ex_ALUSrc   = ex.alu_src;
  assign ex_ALUOp    = ex.alu_op;
  assign ex_WDSel    = ex.wd_sel;
  assign ex_DMType   = ex.dm_type;
  assign ex_NPCOp    = ex.npc_op;
  assign ex_MDOp     = ex.md_op;
  assign ex_MDEn     = ex.md_en;
  assign ex_rd       = ex.rd;
  assign ex_illegal  = ex.illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: expected ID/EX contents are queued as each
// instruction is driven and popped for comparison after the clock edge.
module tb_pipe_ctrl_unit;

  localparam logic [6:0] OP_R = 7'b0110011, OP_L = 7'b0000011, OP_I = 7'b0010011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_FENCE = 7'b0001111;
  localparam logic [6:0] F7_0 = 7'b0000000, F7_ALT = 7'b0100000, F7_M = 7'b0000001;

  typedef struct packed {
    logic       v, rw, mw, mr, as;
    logic [4:0] alu;
    logic [1:0] wd;
    logic [2:0] dm, npc, mdo;
    logic       mde;
    logic [4:0] rd;
    logic       ill;
  } ex_t;

  logic clk, rst, id_valid, flush;
  logic [6:0] Op, Funct7;
  logic [2:0] Funct3;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic [5:0] ext1, ext2;
  logic stall1, stall2, busy1, busy2;
  logic v1, rw1, mw1, mr1, as1, mde1, ill1, v2, rw2, mw2, mr2, as2, mde2, ill2;
  logic [4:0] alu1, alu2, rd1, rd2;
  logic [1:0] wd1, wd2;
  logic [2:0] dm1, dm2, npc1, npc2, mdo1, mdo2;
  ex_t obs1, obs2;

  int total = 0;
  int bad   = 0;
  ex_t q[$];

  pipe_ctrl_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .Op(Op), .Funct7(Funct7), .Funct3(Funct3),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .id_EXTOp(ext1),
    .stall(stall1), .ex_valid(v1), .ex_RegWrite(rw1), .ex_MemWrite(mw1), .ex_MemRead(mr1),
    .ex_ALUSrc(as1), .ex_ALUOp(alu1), .ex_WDSel(wd1), .ex_DMType(dm1), .ex_NPCOp(npc1),
    .ex_MDOp(mdo1), .ex_MDEn(mde1), .ex_rd(rd1), .ex_illegal(ill1), .md_busy(busy1));

  pipe_ctrl_unit #(.EN_MEXT(0)) u_dut_nm (
    .clk(clk), .rst(rst), .id_valid(id_valid), .Op(Op), .Funct7(Funct7), .Funct3(Funct3),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .id_EXTOp(ext2),
    .stall(stall2), .ex_valid(v2), .ex_RegWrite(rw2), .ex_MemWrite(mw2), .ex_MemRead(mr2),
    .ex_ALUSrc(as2), .ex_ALUOp(alu2), .ex_WDSel(wd2), .ex_DMType(dm2), .ex_NPCOp(npc2),
    .ex_MDOp(mdo2), .ex_MDEn(mde2), .ex_rd(rd2), .ex_illegal(ill2), .md_busy(busy2));

  assign obs1 = {v1, rw1, mw1, mr1, as1, alu1, wd1, dm1, npc1, mdo1, mde1, rd1, ill1};
  assign obs2 = {v2, rw2, mw2, mr2, as2, alu2, wd2, dm2, npc2, mdo2, mde2, rd2, ill2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t mk(input logic rw, mw, mr, as, input logic [4:0] alu,
                             input logic [1:0] wd, input logic [2:0] dm, npc, mdo,
                             input logic mde, input logic [4:0] rd, input logic ill);
    mk = {1'b1, rw, mw, mr, as, alu, wd, dm, npc, mdo, mde, rd, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // one ID cycle: drive, check combinational outputs, queue expected ID/EX, clock, compare
  task automatic cyc(input string tag, input logic [6:0] op, f7, input logic [2:0] f3,
                     input logic [4:0] rs1, rs2, rd, input logic v, fl,
                     input logic e_stall, e_busy, input logic [5:0] e_ext, input ex_t e_ex);
    ex_t e;
    Op = op; Funct7 = f7; Funct3 = f3; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_valid = v; flush = fl;
    #1;
    chk({tag, ".stall"}, 32'(stall1), 32'(e_stall));
    chk({tag, ".busy"}, 32'(busy1), 32'(e_busy));
    chk({tag, ".ext"}, 32'(ext1), 32'(e_ext));
    q.push_back(e_ex);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".ex"}, 32'(obs1), 32'(e));
  endtask

  ex_t ADD3, ADD6, DIVE, MULE, BUB;

  initial begin
    BUB  = '0;
    ADD3 = mk(1, 0, 0, 0, 5'd3, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd3, 0);
    ADD6 = mk(1, 0, 0, 0, 5'd3, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd6, 0);
    DIVE = mk(1, 0, 0, 0, 5'd0, 2'b00, 3'd0, 3'd0, 3'b100, 1, 5'd7, 0);
    MULE = mk(1, 0, 0, 0, 5'd0, 2'b00, 3'd0, 3'd0, 3'b000, 1, 5'd11, 0);

    rst = 1'b0; flush = 1'b0; id_valid = 1'b0;
    Op = '0; Funct7 = '0; Funct3 = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    #1 rst = 1'b1;
    // a valid add sits in ID while reset is held
    id_valid = 1'b1; Op = OP_R; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.ex", 32'(obs1), 32'(BUB));
    chk("rst.busy", 32'(busy1), 32'd0);
    chk("rst.stall", 32'(stall1), 32'd0);
    rst = 1'b0;

    cyc("add_first", OP_R, F7_0, 3'b000, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 6'b0, ADD3);
    cyc("lw_x5", OP_L, F7_0, 3'b010, 5'd1, 5'd0, 5'd5, 1, 0, 0, 0, 6'b010000,
        mk(1, 0, 1, 1, 5'd3, 2'b01, 3'b000, 3'd0, 3'd0, 0, 5'd5, 0));
    cyc("lu_stall", OP_R, F7_0, 3'b000, 5'd5, 5'd2, 5'd6, 1, 0, 1, 0, 6'b0, BUB);
    cyc("lu_resume", OP_R, F7_0, 3'b000, 5'd5, 5'd2, 5'd6, 1, 0, 0, 0, 6'b0, ADD6);
    cyc("lw_x0", OP_L, F7_0, 3'b010, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, 6'b010000,
        mk(1, 0, 1, 1, 5'd3, 2'b01, 3'b000, 3'd0, 3'd0, 0, 5'd0, 0));
    cyc("lu_x0", OP_R, F7_0, 3'b000, 5'd0, 5'd2, 5'd6, 1, 0, 0, 0, 6'b0, ADD6);
    cyc("lbu_x5", OP_L, F7_0, 3'b100, 5'd1, 5'd0, 5'd5, 1, 0, 0, 0, 6'b010000,
        mk(1, 0, 1, 1, 5'd3, 2'b01, 3'b100, 3'd0, 3'd0, 0, 5'd5, 0));
    cyc("lu_flush", OP_R, F7_0, 3'b000, 5'd5, 5'd2, 5'd6, 1, 1, 0, 0, 6'b0, BUB);
    cyc("addi_redir", OP_I, F7_0, 3'b000, 5'd1, 5'd5, 5'd4, 1, 0, 0, 0, 6'b010000,
        mk(1, 0, 0, 1, 5'd3, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd4, 0));

    cyc("div_load", OP_R, F7_M, 3'b100, 5'd8, 5'd9, 5'd7, 1, 0, 0, 0, 6'b0, DIVE);
    for (int k = 1; k <= 7; k++)
      cyc($sformatf("div_hold%0d", k), OP_R, F7_ALT, 3'b000, 5'd1, 5'd2, 5'd10, 1, 0, 1, 1,
          6'b0, DIVE);
    cyc("div_next", OP_R, F7_ALT, 3'b000, 5'd1, 5'd2, 5'd10, 1, 0, 0, 0, 6'b0,
        mk(1, 0, 0, 0, 5'd4, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd10, 0));
    cyc("mul_load", OP_R, F7_M, 3'b000, 5'd1, 5'd2, 5'd11, 1, 0, 0, 0, 6'b0, MULE);
    cyc("mul_hold", OP_R, F7_0, 3'b001, 5'd1, 5'd2, 5'd12, 1, 0, 1, 1, 6'b0, MULE);
    cyc("mul_next", OP_R, F7_0, 3'b001, 5'd1, 5'd2, 5'd12, 1, 0, 0, 0, 6'b0,
        mk(1, 0, 0, 0, 5'd15, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd12, 0));

    cyc("srai", OP_I, F7_ALT, 3'b101, 5'd1, 5'd3, 5'd13, 1, 0, 0, 0, 6'b100000,
        mk(1, 0, 0, 1, 5'd17, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd13, 0));
    cyc("beq", OP_B, F7_0, 3'b000, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0, 6'b000100,
        mk(0, 0, 0, 0, 5'd4, 2'b00, 3'd0, 3'b001, 3'd0, 0, 5'd0, 0));
    cyc("sw", OP_S, F7_0, 3'b010, 5'd1, 5'd2, 5'd4, 1, 0, 0, 0, 6'b001000,
        mk(0, 1, 0, 1, 5'd3, 2'b00, 3'b000, 3'd0, 3'd0, 0, 5'd4, 0));
    cyc("jal", OP_JAL, F7_0, 3'b000, 5'd0, 5'd0, 5'd1, 1, 0, 0, 0, 6'b000001,
        mk(1, 0, 0, 0, 5'd3, 2'b10, 3'd0, 3'b010, 3'd0, 0, 5'd1, 0));
    cyc("jalr", OP_JALR, F7_0, 3'b000, 5'd5, 5'd0, 5'd1, 1, 0, 0, 0, 6'b010000,
        mk(1, 0, 0, 1, 5'd3, 2'b10, 3'd0, 3'b100, 3'd0, 0, 5'd1, 0));
    cyc("lui", OP_LUI, F7_0, 3'b000, 5'd0, 5'd0, 5'd14, 1, 0, 0, 0, 6'b000010,
        mk(1, 0, 0, 1, 5'd1, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd14, 0));
    cyc("fence", OP_FENCE, F7_0, 3'b000, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 6'b0,
        mk(0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd0, 1));
    chk("fence_nm.ex", 32'(obs2), 32'(mk(0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd0, 1)));

    cyc("mul_m", OP_R, F7_M, 3'b000, 5'd2, 5'd3, 5'd1, 1, 0, 0, 0, 6'b0,
        mk(1, 0, 0, 0, 5'd0, 2'b00, 3'd0, 3'd0, 3'b000, 1, 5'd1, 0));
    chk("mul_nm.ex", 32'(obs2), 32'(mk(0, 0, 0, 0, 5'd0, 2'b00, 3'd0, 3'd0, 3'd0, 0, 5'd1, 1)));
    chk("mul_nm.busy", 32'(busy2), 32'd0);
    cyc("mul_m_hold", OP_R, F7_0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 6'b0,
        mk(1, 0, 0, 0, 5'd0, 2'b00, 3'd0, 3'd0, 3'b000, 1, 5'd1, 0));
    chk("mul_nm.busy2", 32'(busy2), 32'd0);
    cyc("idle", OP_R, F7_0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 6'b0, BUB);

    cyc("div2_load", OP_R, F7_M, 3'b100, 5'd8, 5'd9, 5'd7, 1, 0, 0, 0, 6'b0, DIVE);
    cyc("div2_hold1", OP_R, F7_0, 3'b000, 5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 6'b0, DIVE);
    cyc("div2_hold2", OP_R, F7_0, 3'b000, 5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 6'b0, DIVE);
    rst = 1'b1;
    #1;
    chk("arst.busy", 32'(busy1), 32'd0);
    chk("arst.stall", 32'(stall1), 32'd0);
    chk("arst.ex", 32'(obs1), 32'(BUB));
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("arst_resume", OP_R, F7_0, 3'b000, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 6'b0, ADD3);
    cyc("arst_after", OP_R, F7_0, 3'b000, 5'd3, 5'd2, 5'd6, 1, 0, 0, 0, 6'b0, ADD6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined control unit for the RV32 core. Decodes the ID-stage instruction using the encodings in ctrl_encode_def.v.
- Registers the resulting controls into the ID/EX control register.
- Detects load-use hazards and applies redirect flushes.
- Sequences multi-cycle RV32M MUL/DIV ops with a busy counter that holds the front end.
- Sits between the IF/ID register and the EX stage, with its outputs feeding the EX/MEM/WB control chain.

Parameters:
ALUOP_W, 5, ALUOp width (ALUOp_add = 5'b00011)
EXTOP_W, 6, EXTOp width (one-hot immediate select)
EN_MEXT, 1, 1 = decode RV32M; 0 = M-ext encodings flagged illegal
MUL_LAT, 2, EX occupancy in cycles for MUL/MULH/MULHSU/MULHU (>=1)
DIV_LAT, 8, EX occupancy in cycles for DIV/DIVU/REM/REMU (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
id_valid  input  1  IF/ID holds a real instruction
Op  input  7  ID opcode
Funct7  input  7  ID funct7
Funct3  input  3  ID funct3
id_rs1  input  5  ID source register 1
id_rs2  input  5  ID source register 2
id_rd  input  5  ID destination register
flush  input  1  EX-stage redirect (taken branch/jal/jalr)
id_EXTOp  output  EXTOP_W  combinational immediate select for ID immgen
stall  output  1  hold PC and IF/ID
ex_valid  output  1  ID/EX holds a real instruction
ex_RegWrite  output  1  registered
ex_MemWrite  output  1  registered
ex_MemRead  output  1  registered, loads only
ex_ALUSrc  output  1  registered
ex_ALUOp  output  ALUOP_W  registered
ex_WDSel  output  2  registered (00 ALU, 01 MEM, 10 PC+4)
ex_DMType  output  3  registered (000 word, 001 half, 010 half-u, 011 byte, 100 byte-u)
ex_NPCOp  output  3  registered branch/jump kind (bit0 branch, bit1 jal, bit2 jalr); EX resolves
ex_MDOp  output  3  registered funct3 of the M-ext op; 0 when ex_MDEn=0
ex_MDEn  output  1  registered, EX instruction is M-ext
ex_rd  output  5  registered
ex_illegal  output  1  registered, unsupported encoding reached EX
md_busy  output  1  M-ext op still occupying EX

Behaviour:
- Decode (combinational, ID):
  - Supported classes: R-type, load, I-ALU incl. shifts, store, branch, jal, jalr, lui, auipc.
  - R-type with Funct7 = 0000001 is M-ext; decoded only when EN_MEXT = 1.
  - Any other encoding sets illegal. An illegal instruction carries RegWrite = MemWrite = 0.
- Register use: uses_rs1 is false for lui, auipc and jal. uses_rs2 is true only for R-type, store and branch.
- Reset (async, rst = 1): all ex_* = 0, ex_valid = 0, md counter = 0, md_busy = 0. stall is 0 while rst is high.
- Per clock edge, first matching rule wins:
  1. md_busy: ID/EX holds its contents; stall = 1.
  2. flush: ID/EX loads a bubble (ex_valid and all ex_* = 0). stall = 0, so IF/ID and PC are overwritten by the redirect.
  3. load_use: ID/EX loads a bubble; stall = 1.
  4. Otherwise: ID/EX loads the decoded controls, gated by id_valid (id_valid = 0 loads a bubble).
- load_use = id_valid & ex_valid & ex_MemRead & (ex_rd != 0) & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- stall = md_busy | (load_use & ~flush). It is combinational and has zero-cycle latency to the PC and IF/ID enables.
- MD counter:
  - On the edge that loads an M-ext op into ID/EX, the counter loads MUL_LAT-1 or DIV_LAT-1.
  - md_busy = (counter != 0). The counter decrements each cycle while nonzero.
  - With LAT = 1 there is no busy cycle.
  - The op leaves EX on the edge after the counter reaches 0.
- flush during md_busy cannot occur legally, because an M-ext op is never a redirect. If it is asserted anyway, it is ignored and the counter continues.
- A load-use hazard against an M-ext producer does not exist (ex_MemRead = 0 for M-ext ops).
- Writes to x0 are not suppressed here; the register file ignores rd = 0.
- rst asserted mid-MD op: the counter clears immediately and md_busy drops asynchronously.

Test Plan:
- Reset: hold rst = 1 mid-stream → all ex_* = 0, md_busy = 0, stall = 0. After release, the first add x3,x1,x2 gives ex_valid = 1, ex_ALUOp = 5'b00011, ex_RegWrite = 1 one cycle later.
- Load-use: lw x5,0(x1) then add x6,x5,x2 → stall = 1 for exactly one cycle, then one bubble (ex_valid = 0). The add enters EX next; the lw showed ex_WDSel = 01, ex_DMType = 000. Repeat with rd = x0 → no stall.
- Flush priority: flush = 1 in the same cycle as a load-use hazard → stall = 0, bubble loaded, no extra hold cycle.
- DIV with DIV_LAT = 8: div x7,x8,x9 loaded → md_busy = 1 and stall = 1 for 7 cycles with ID/EX unchanged (ex_MDEn = 1, ex_MDOp = 100). The next instruction enters EX on the 9th edge. mul with MUL_LAT = 2 → exactly 1 busy cycle.
- EN_MEXT = 0: mul x1,x2,x3 → ex_illegal = 1, ex_RegWrite = 0, md_busy never asserted. Opcode 0001111 behaves the same under either setting.
- Async reset during md_busy (cycle 3 of a div) → md_busy and stall fall before the next clock edge; the pipeline resumes cleanly.
